// File: rtl/mem_port.sv
// mem_port: memory access unit for the shared 16-bit datapath bus.
// It captures bus addresses into MAR and runs one req/ack transaction to
// external memory at a time. Read data, or write data taken from the bus,
// is held in MDR. MDR is driven back onto the bus through a tri-state
// output, and a one-cycle ready pulse (R) tells the control unit that the
// access has finished.
//
// Ports:
//   clk, reset       clock; synchronous active-low reset
//   en               drive MDR onto mdr_out (high-Z otherwise)
//   ld_mar, ld_mdr   load MAR / MDR from bus (only while idle)
//   mio_en, r_w      start a transaction at MAR; r_w=1 write, 0 read
//   bus              shared datapath bus
//   mdr_out          tri-state MDR output
//   ready            one-cycle completion pulse
//   err              sticky misalign/timeout flag
//   mem_addr/wdata   MAR / MDR toward memory
//   mem_req/we       request and write enable toward memory
//   mem_rdata/ack    read data and single-cycle acknowledge from memory
module mem_port #(
  parameter int TIMEOUT = 16,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             mio_en,
  input  logic             r_w,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] mdr_out,
  output logic             ready,
  output logic             err,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_req,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  // The counter keeps at least one bit, even when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mar;
  logic [WIDTH-1:0] mdr;
  logic             we_q;
  logic             err_q;
  logic [CW-1:0]    wait_cnt;
  logic [CW-1:0]    cnt_next;
  logic             timeout_hit;

  // The wait counter saturates instead of wrapping. A timeout fires on the
  // edge where the count would reach TIMEOUT, so mem_req stays high for
  // exactly TIMEOUT cycles.
  always_comb begin
    cnt_next    = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
    timeout_hit = (TIMEOUT != 0) && (cnt_next == CW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      mar      <= '0;
      mdr      <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_mar) mar <= bus;
          if (ld_mdr) mdr <= bus;
          // mio_en uses the MAR value from before this edge, so a
          // same-cycle ld_mar does not affect the access.
          if (mio_en) begin
            wait_cnt <= '0;
            if (mar[0]) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              err_q <= 1'b0;
              we_q  <= r_w;
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (!we_q) mdr <= mem_rdata;
            state <= S_DONE;
          end else begin
            wait_cnt <= cnt_next;
            if (timeout_hit) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = (state == S_REQ);
  assign mem_we    = we_q && (state == S_REQ);
  assign ready     = (state == S_DONE);
  assign err       = err_q;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign mdr_out   = en ? mdr : 'z;

endmodule

// File: tb/tb_mem_port.sv
// Directed testbench for mem_port. Each transaction pushes its expected
// latency, request-cycle count, MDR value and err value into a queue. The
// entry is popped and compared when ready is seen.
module tb_mem_port;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic        ld_mar = 1'b0;
  logic        ld_mdr = 1'b0;
  logic        mio_en = 1'b0;
  logic        r_w = 1'b0;
  logic [15:0] bus = '0;
  logic [15:0] mdr_out;
  logic        ready;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  typedef struct {
    int          lat;
    int          reqc;
    logic [15:0] mdr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdr_model = '0;
  logic [15:0] zz = 'z;
  int          checks = 0;
  int          failures = 0;

  mem_port #(.TIMEOUT(TMO), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .en(en), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .bus(bus), .mdr_out(mdr_out),
    .ready(ready), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic load(input bit m, input bit d, input logic [15:0] v);
    bus = v; ld_mar = m; ld_mdr = d;
    step();
    ld_mar = 1'b0; ld_mdr = 1'b0; bus = '0;
    if (m) chk("mar_load", mem_addr, v);
    if (d) begin
      mdr_model = v;
      chk("mdr_load", mdr_out, v);
    end
  endtask

  // Start an access at the current MAR and serve it as memory, then check it.
  // waits = number of REQ cycles before the ack. ack=0 lets it time out.
  // disturb drives ld_mar/ld_mdr/mio_en while REQ is active; they must be ignored.
  task automatic do_txn(input string name, input logic rw, input logic [15:0] addr,
                        input int waits, input bit ack, input logic [15:0] rdata,
                        input bit disturb);
    exp_t e;
    exp_t g;
    int   lat;
    int   reqc;
    e.err = addr[0] || !ack;
    if (addr[0]) begin
      e.lat = 1; e.reqc = 0;
    end else if (!ack) begin
      e.lat = TMO + 1; e.reqc = TMO;
    end else begin
      e.lat = waits + 2; e.reqc = waits + 1;
      if (!rw) mdr_model = rdata;
    end
    e.mdr = mdr_model;
    sb.push_back(e);

    mio_en = 1'b1; r_w = rw;
    step();
    mio_en = 1'b0; r_w = 1'b0;
    lat = 1; reqc = 0;
    while (!ready && lat < 40) begin
      if (mem_req) begin
        reqc++;
        chk({name, "_addr"}, mem_addr, addr);
        chk({name, "_we"}, mem_we, rw);
        chk({name, "_err_req"}, err, 1'b0);
        if (rw) chk({name, "_wdata"}, mem_wdata, mdr_model);
        if (ack && reqc == waits + 1) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
        if (disturb) begin
          ld_mar = 1'b1; ld_mdr = 1'b1; mio_en = 1'b1; bus = 16'hFFF0;
        end
      end
      step();
      mem_ack = 1'b0; mem_rdata = '0;
      ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; bus = '0;
      lat++;
    end
    g = sb.pop_front();
    chk({name, "_ready_seen"}, ready, 1'b1);
    chk({name, "_latency"}, lat, g.lat);
    chk({name, "_req_cycles"}, reqc, g.reqc);
    chk({name, "_mdr"}, mdr_out, g.mdr);
    chk({name, "_err"}, err, g.err);
    // mio_en while in DONE must be ignored, and ready lasts one cycle only.
    mio_en = 1'b1;
    step();
    mio_en = 1'b0;
    chk({name, "_ready_drop"}, ready, 1'b0);
    chk({name, "_no_req_after"}, mem_req, 1'b0);
  endtask

  initial begin
    // Reset for two cycles.
    step();
    step();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_mar", mem_addr, 16'h0000);
    chk("rst_mdr_en1", mdr_out, 16'h0000);
    en = 1'b0;
    #1;
    chk("rst_mdr_en0", mdr_out, zz);
    en = 1'b1;
    reset = 1'b1;
    step();

    // Read with the ack in the first REQ cycle.
    load(1'b1, 1'b0, 16'h3000);
    do_txn("rd0", 1'b0, 16'h3000, 0, 1'b1, 16'h1234, 1'b0);

    // Write with three wait cycles.
    load(1'b1, 1'b0, 16'h4002);
    load(1'b0, 1'b1, 16'hBEEF);
    do_txn("wr3", 1'b1, 16'h4002, 3, 1'b1, 16'h0000, 1'b0);

    // Misaligned access: no request, err stays set while idle.
    load(1'b1, 1'b0, 16'h3001);
    do_txn("mis", 1'b0, 16'h3001, 0, 1'b1, 16'h0000, 1'b0);
    chk("mis_err_sticky", err, 1'b1);

    // The next aligned access clears err.
    load(1'b1, 1'b0, 16'h3002);
    do_txn("rd1", 1'b0, 16'h3002, 1, 1'b1, 16'h5A5A, 1'b0);

    // Timeout, with loads/mio_en driven during REQ that must be ignored.
    load(1'b1, 1'b0, 16'h3004);
    do_txn("tmo", 1'b0, 16'h3004, 0, 1'b0, 16'h0000, 1'b1);

    // Both loads in the same cycle.
    load(1'b1, 1'b1, 16'h6000);

    // Reset in the middle of a transaction, then a late ack arrives in IDLE.
    load(1'b1, 1'b0, 16'h3006);
    mio_en = 1'b1; r_w = 1'b0;
    step();
    mio_en = 1'b0;
    chk("mid_req_up", mem_req, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    mdr_model = '0;
    chk("mid_req_drop", mem_req, 1'b0);
    chk("mid_ready", ready, 1'b0);
    chk("mid_mdr", mdr_out, 16'h0000);
    chk("mid_mar", mem_addr, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("late_ack_ready", ready, 1'b0);
    chk("late_ack_req", mem_req, 1'b0);
    chk("late_ack_mdr", mdr_out, 16'h0000);
    step();
    chk("late_ack_ready2", ready, 1'b0);
    en = 1'b0;
    #1;
    chk("end_mdr_z", mdr_out, zz);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port.md
Name: mem_port

Overview:
- Memory access unit on the other end of the PC/address path: captures addresses driven onto the shared 16-bit bus (PC, effective address) into MAR.
- Runs a request/acknowledge transaction to external memory and holds read or write data in MDR.
- Drives MDR back onto the shared bus through a tri-state output.
- Supplies the control unit with the ready (R) indication that paces fetch and load/store states.

Parameters:
- TIMEOUT, 16, max cycles waiting for mem_ack before abort; 0 disables the timeout.
- WIDTH, 16, address and data width.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- en  in  1  drive MDR onto mdr_out; high-Z when 0.
- ld_mar  in  1  load MAR from bus.
- ld_mdr  in  1  load MDR from bus (write data path).
- mio_en  in  1  start memory transaction at MAR.
- r_w  in  1  transaction direction, 1 = write, 0 = read; sampled with mio_en.
- bus  in  WIDTH  shared datapath bus.
- mdr_out  out  WIDTH  MDR when en=1, else all Z.
- ready  out  1  one-cycle pulse when a transaction completes (R).
- err  out  1  sticky: misaligned access or timeout; cleared by reset or next accepted mio_en.
- mem_addr  out  WIDTH  address to memory (MAR).
- mem_wdata  out  WIDTH  write data (MDR).
- mem_req  out  1  request, held until ack or abort.
- mem_we  out  1  write enable, valid while mem_req=1.
- mem_rdata  in  WIDTH  read data, valid when mem_ack=1.
- mem_ack  in  1  memory acknowledge, single cycle.

Behaviour:
- Reset (reset=0 at posedge): MAR=0, MDR=0, state=IDLE, mem_req=0, mem_we=0, ready=0, err=0, wait counter=0. mdr_out follows en regardless of reset (Z or 0).
- Reset asserted mid-transaction: returns to IDLE next edge and drops mem_req immediately. A late mem_ack arriving in IDLE is ignored.
- Addresses are byte addresses, words are 2 bytes, so bit 0 of MAR must be 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - ld_mar loads MAR and ld_mdr loads MDR; both may assert in the same cycle.
  - On mio_en with MAR[0]=0: latch r_w into mem_we, assert mem_req, go to REQ, clear err and the wait counter.
  - On mio_en with MAR[0]=1: no request, err=1, ready pulses next cycle (DONE), MDR unchanged.
  - mio_en in the same cycle as ld_mar uses the old MAR. The control unit sequences ld_mar one state earlier.
- REQ:
  - mem_req=1; mem_addr=MAR, mem_wdata=MDR, both stable.
  - ld_mar, ld_mdr and mio_en are ignored.
  - On mem_ack: a read loads MDR from mem_rdata; a write leaves MDR unchanged. Drop mem_req next cycle and go to DONE.
  - Ack in the first REQ cycle is legal, giving minimum latency of mio_en to ready = 2 cycles.
  - Wait counter increments each REQ cycle without ack. When TIMEOUT≠0 and the counter reaches TIMEOUT: err=1, drop mem_req, go to DONE, MDR unchanged.
- DONE: ready=1 for exactly one cycle, then IDLE. A new mio_en is accepted only in IDLE; in DONE it is ignored.
- Counter width is clog2(TIMEOUT+1). It saturates and does not wrap.

Test Plan:
- Reset then idle: reset=0 for 2 cycles → mem_req=0, ready=0, err=0. With en=1, mdr_out=0x0000; with en=0, mdr_out=Z.
- Read, zero wait:
  - Stimulus: bus=0x3000 with ld_mar; mio_en, r_w=0; mem_ack with mem_rdata=0x1234 in the first REQ cycle.
  - Required: mem_addr=0x3000, mem_we=0, ready pulses 2 cycles after mio_en, mdr_out=0x1234 with en=1.
- Write, 3 wait cycles:
  - Stimulus: MAR=0x4002, ld_mdr with bus=0xBEEF, mio_en with r_w=1, ack after 3 cycles.
  - Required: mem_we=1, mem_wdata=0xBEEF held stable throughout, ready 5 cycles after mio_en.
- Misaligned access: MAR=0x3001, mio_en → mem_req never rises, err=1, ready pulses once. A following aligned mio_en clears err.
- Timeout: TIMEOUT=4, no ack → mem_req high for 4 cycles, then err=1, ready pulses, MDR keeps its prior value.
- Reset mid-transaction:
  - Stimulus: reset=0 while in REQ, then ack asserted one cycle later.
  - Required: mem_req=0 after the edge, MDR=0, no ready pulse.
